// File: rtl/video_bringup_sequencer.sv
// Bring-up sequencer for the VGA video pipeline: releases timing, fetch and pixel resets in order,
// then enables video on a frame boundary. Define SEQ_TIMEOUT_EN to add the WAIT_PRIME watchdog.
module video_bringup_sequencer #(
    parameter int STAB_CYCLES    = 256,
    parameter int GAP_CYCLES     = 8,
    parameter int SOFT_HOLD      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       VGA_CLK,
    input  logic       e_reset,
    input  logic       soft_rst_req,
    input  logic       fifo_ready,
    input  logic       vsync_pulse,
    output logic       timing_rst_n,
    output logic       fetch_rst_n,
    output logic       pixel_rst_n,
    output logic       video_en,
    output logic       seq_busy,
    output logic       err_timeout,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_HOLD       = 4'd0,
        S_STAB       = 4'd1,
        S_REL_T      = 4'd2,
        S_REL_F      = 4'd3,
        S_WAIT_PRIME = 4'd4,
        S_WAIT_FRAME = 4'd5,
        S_RUN        = 4'd6,
        S_SOFT       = 4'd7,
        S_FAULT      = 4'd8
    } state_t;

    localparam int M1 = (STAB_CYCLES > GAP_CYCLES) ? STAB_CYCLES : GAP_CYCLES;
    localparam int M2 = (M1 > SOFT_HOLD) ? M1 : SOFT_HOLD;
`ifdef SEQ_TIMEOUT_EN
    localparam int MAXP = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
`else
    localparam int MAXP = (TIMEOUT_CYCLES >= 0) ? M2 : M2;
`endif
    localparam int CW = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

    localparam logic [CW-1:0] STAB_L = STAB_CYCLES[CW-1:0];
    localparam logic [CW-1:0] GAP_L  = GAP_CYCLES[CW-1:0];
    localparam logic [CW-1:0] SOFT_L = SOFT_HOLD[CW-1:0];
`ifdef SEQ_TIMEOUT_EN
    // Loaded one short so the fault lands after exactly TIMEOUT_CYCLES clocks in WAIT_PRIME.
    localparam int            TO_M1  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_L   = TO_M1[CW-1:0];
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q, sync_d;
    logic          timing_q, timing_d;
    logic          fetch_q, fetch_d;
    logic          pixel_q, pixel_d;
    logic          video_q, video_d;
    logic          busy_q, busy_d;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        sync_d  = {sync_q[0], 1'b1};
        case (state_q)
            S_HOLD: begin
                if (sync_q[1]) begin
                    state_d = S_STAB;
                    cnt_d   = STAB_L;
                end
            end
            S_STAB, S_SOFT: begin
                if (cnt_zero) begin
                    state_d = S_REL_T;
                    cnt_d   = GAP_L;
                end
            end
            S_REL_T: begin
                if (cnt_zero) state_d = S_REL_F;
            end
            S_REL_F: begin
                state_d = S_WAIT_PRIME;
`ifdef SEQ_TIMEOUT_EN
                cnt_d   = TO_L;
`endif
            end
            S_WAIT_PRIME: begin
`ifdef SEQ_TIMEOUT_EN
                if (cnt_zero) state_d = S_FAULT;
                else if (fifo_ready) state_d = S_WAIT_FRAME;
`else
                if (fifo_ready) state_d = S_WAIT_FRAME;
`endif
            end
            S_WAIT_FRAME: begin
                if (vsync_pulse) begin
                    state_d = S_RUN;
                end else if (!fifo_ready) begin
                    state_d = S_WAIT_PRIME;
`ifdef SEQ_TIMEOUT_EN
                    cnt_d   = TO_L;
`endif
                end
            end
            S_RUN, S_FAULT: begin
                state_d = state_q;
            end
            default: state_d = S_HOLD;
        endcase
        // Re-init wins over everything; holding it high keeps reloading the hold counter.
        if (soft_rst_req && state_q != S_HOLD) begin
            state_d = S_SOFT;
            cnt_d   = SOFT_L;
        end
        timing_d = state_d inside {S_REL_T, S_REL_F, S_WAIT_PRIME, S_WAIT_FRAME, S_RUN};
        fetch_d  = state_d inside {S_REL_F, S_WAIT_PRIME, S_WAIT_FRAME, S_RUN};
        pixel_d  = state_d inside {S_WAIT_FRAME, S_RUN};
        video_d  = (state_d == S_RUN);
        busy_d   = (state_d != S_RUN);
    end

    always_ff @(posedge VGA_CLK or negedge e_reset) begin
        if (!e_reset) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            sync_q   <= 2'b00;
            timing_q <= 1'b0;
            fetch_q  <= 1'b0;
            pixel_q  <= 1'b0;
            video_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            timing_q <= timing_d;
            fetch_q  <= fetch_d;
            pixel_q  <= pixel_d;
            video_q  <= video_d;
            busy_q   <= busy_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_d == S_FAULT) err_d = 1'b1;
        else if (state_d == S_SOFT) err_d = 1'b0;
    end

    always_ff @(posedge VGA_CLK or negedge e_reset) begin
        if (!e_reset) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign timing_rst_n = timing_q;
    assign fetch_rst_n  = fetch_q;
    assign pixel_rst_n  = pixel_q;
    assign video_en     = video_q;
    assign seq_busy     = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_video_bringup_sequencer.sv
// Scoreboard bench for video_bringup_sequencer: each scenario queues the expected state/outputs
// per clock index and compares them as the clocks go by.
module tb_video_bringup_sequencer;

    localparam logic [3:0] HOLD = 4'd0, STAB = 4'd1, REL_T = 4'd2, REL_F = 4'd3,
                           WP = 4'd4, WF = 4'd5, RUN = 4'd6, SOFT = 4'd7, FAULT = 4'd8;

    logic       VGA_CLK = 1'b0;
    logic       e_reset = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       fifo_ready = 1'b0;
    logic       vsync_pulse = 1'b0;
    logic       timing_rst_n, fetch_rst_n, pixel_rst_n, video_en, seq_busy, err_timeout;
    logic [3:0] state_o;
    logic [5:0] obs;

    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        int         at;
        logic [3:0] st;
        logic [5:0] o;
        string      tag;
    } exp_t;
    exp_t sbq[$];

    video_bringup_sequencer #(
        .STAB_CYCLES(16), .GAP_CYCLES(4), .SOFT_HOLD(8), .TIMEOUT_CYCLES(100)
    ) dut (
        .VGA_CLK(VGA_CLK), .e_reset(e_reset), .soft_rst_req(soft_rst_req),
        .fifo_ready(fifo_ready), .vsync_pulse(vsync_pulse),
        .timing_rst_n(timing_rst_n), .fetch_rst_n(fetch_rst_n), .pixel_rst_n(pixel_rst_n),
        .video_en(video_en), .seq_busy(seq_busy), .err_timeout(err_timeout), .state_o(state_o)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    assign obs = {timing_rst_n, fetch_rst_n, pixel_rst_n, video_en, seq_busy, err_timeout};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // {timing, fetch, pixel, video, busy, err} as the state table describes them.
    function automatic logic [5:0] vec_of(input logic [3:0] s);
        case (s)
            REL_T:           return 6'b100010;
            REL_F, WP:       return 6'b110010;
            WF:              return 6'b111010;
            RUN:             return 6'b111100;
            FAULT:           return 6'b000011;
            default:         return 6'b000010;
        endcase
    endfunction

    task automatic push(input int at, input logic [3:0] st, input string tag);
        exp_t e;
        e.at = at; e.st = st; e.o = vec_of(st); e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_tot++;
        if (state_o !== HOLD) begin
            n_bad++;
            $display("FAIL reset_state got=%0d need=%0d", state_o, HOLD);
        end else $display("ok reset_state st=%0d", state_o);
        n_tot++;
        if (obs !== 6'b000010) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b need=%b", obs, 6'b000010);
        end else $display("ok reset_outputs o=%b", obs);
    endtask

    task automatic test_bringup();
        exp_t e;
        fifo_ready = 1'b1;
        e_reset    = 1'b1;
        push(0, HOLD, "sync0"); push(1, HOLD, "sync1"); push(2, STAB, "stab_in");
        push(18, STAB, "stab_end"); push(19, REL_T, "rel_t"); push(23, REL_T, "gap_end");
        push(24, REL_F, "rel_f"); push(25, WP, "prime"); push(26, WF, "frame");
        push(40, WF, "frame_wait"); push(41, RUN, "run");
        for (int t = 0; t <= 42; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
            vsync_pulse = (t == 40);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    task automatic test_soft_run();
        exp_t e;
        push(0, RUN, "run_pre"); push(1, SOFT, "soft_in"); push(9, SOFT, "soft_hold");
        push(10, REL_T, "soft_relt"); push(15, REL_F, "soft_relf"); push(16, WP, "soft_prime");
        push(17, WF, "soft_frame"); push(21, RUN, "soft_run");
        for (int t = 0; t <= 22; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
            soft_rst_req = (t == 0);
            vsync_pulse  = (t == 20);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    task automatic test_soft_extend();
        exp_t e;
        push(0, RUN, "ext_pre"); push(1, SOFT, "ext_in"); push(12, SOFT, "ext_hold");
        push(13, REL_T, "ext_relt"); push(18, REL_F, "ext_relf"); push(19, WP, "ext_prime");
        push(20, WF, "ext_frame"); push(23, RUN, "ext_run");
        for (int t = 0; t <= 24; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
            soft_rst_req = (t <= 3);
            vsync_pulse  = (t == 22);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    task automatic test_fifo_drop();
        exp_t e;
        push(17, WF, "drop_frame"); push(19, WP, "drop_prime"); push(20, WF, "drop_reframe");
        push(21, WF, "early_vsync_ignored"); push(25, WF, "drop_wait"); push(26, RUN, "drop_run");
        for (int t = 0; t <= 27; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
            soft_rst_req = (t == 0);
            fifo_ready   = (t != 18);
            vsync_pulse  = (t == 19) || (t == 25);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    task automatic test_soft_vsync();
        exp_t e;
        push(17, WF, "sv_frame"); push(19, SOFT, "sv_soft_wins"); push(27, SOFT, "sv_hold");
        push(28, REL_T, "sv_relt"); push(37, RUN, "sv_run");
        for (int t = 0; t <= 38; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
            soft_rst_req = (t == 0) || (t == 18);
            vsync_pulse  = (t == 18) || (t == 36);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    task automatic test_prime_timeout();
        exp_t e;
        int   last;
`ifdef SEQ_TIMEOUT_EN
        push(0, RUN, "to_pre"); push(1, SOFT, "to_soft"); push(16, WP, "to_prime");
        push(115, WP, "to_still_prime"); push(116, FAULT, "to_fault"); push(120, FAULT, "to_fault_held");
        push(121, SOFT, "to_clear"); push(130, REL_T, "to_relt"); push(136, WP, "to_reprime");
        push(137, WF, "to_frame"); push(141, RUN, "to_run");
        last = 142;
`else
        push(0, RUN, "nt_pre"); push(16, WP, "nt_prime"); push(117, WP, "nt_no_fault");
        push(200, WP, "nt_still_prime"); push(201, WF, "nt_frame"); push(204, RUN, "nt_run");
        last = 205;
`endif
        for (int t = 0; t <= last; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
`ifdef SEQ_TIMEOUT_EN
            soft_rst_req = (t == 0) || (t == 120);
            fifo_ready   = (t >= 120);
            vsync_pulse  = (t == 140);
`else
            soft_rst_req = (t == 0);
            fifo_ready   = (t >= 200);
            vsync_pulse  = (t == 203);
`endif
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        tick();
        n_tot++;
        if (state_o !== RUN) begin
            n_bad++;
            $display("FAIL ar_pre got=%0d need=%0d", state_o, RUN);
        end else $display("ok ar_pre st=%0d", state_o);
        #2 e_reset = 1'b0;
        #1;
        n_tot++;
        if ({state_o, obs} !== {HOLD, 6'b000010}) begin
            n_bad++;
            $display("FAIL ar_async got st=%0d o=%b need st=%0d o=%b", state_o, obs, HOLD, 6'b000010);
        end else $display("ok ar_async st=%0d o=%b", state_o, obs);
        tick();
        e_reset = 1'b1;
        push(1, HOLD, "ar_sync"); push(2, STAB, "ar_stab"); push(19, REL_T, "ar_relt");
        for (int t = 0; t <= 20; t++) begin
            tick();
            if (sbq.size() > 0 && sbq[0].at == t) begin
                e = sbq.pop_front();
                n_tot++;
                if ({state_o, obs} !== {e.st, e.o}) begin
                    n_bad++;
                    $display("FAIL %s t=%0d got st=%0d o=%b need st=%0d o=%b", e.tag, t, state_o, obs, e.st, e.o);
                end else $display("ok %s t=%0d st=%0d o=%b", e.tag, t, state_o, obs);
            end
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); n_tot++; n_bad++;
            $display("FAIL %s never checked need st=%0d", e.tag, e.st);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_soft_run();
        test_soft_extend();
        test_fifo_drop();
        test_soft_vsync();
        test_prime_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
